// File: rtl/parser_in_arb.sv
`default_nettype none
// ============================================================================
//  Module   : parser_in_arb
//  Purpose  : Packet-level round-robin arbiter that shares the single 32-bit
//             stream input of the packet parser between NUM_SRC sources.
//             The grant is held from the first beat to the accepted last beat.
//             Packets longer than MAX_BEATS are cut short: the parser sees a
//             forced last, the rest of the source packet is drained, and
//             oversize_err pulses once.
//  Ports    : clk, reset         - clock, synchronous active-high reset
//             src_data/val/last  - per-source stream (source i in slice i)
//             src_ready          - per-source ready
//             src_en             - per-source arbitration enable
//             out_data/val/last  - stream to the parser
//             out_ready          - parser ready
//             out_src            - granted source index (valid while busy)
//             busy               - a packet is being passed or drained
//             oversize_err       - one-cycle pulse per truncated packet
//  Revision : 1.0  initial release
// ============================================================================
module parser_in_arb #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BEATS = 12,
    parameter int SRC_W     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC*32-1:0]  src_data,
    input  logic [NUM_SRC-1:0]     src_val,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic [NUM_SRC-1:0]     src_en,
    output logic [31:0]            out_data,
    output logic                   out_val,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [SRC_W-1:0]       out_src,
    output logic                   busy,
    output logic                   oversize_err
);

    localparam int               c_CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BEATS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(MAX_BEATS);
    localparam logic [SRC_W-1:0] c_LAST_SRC = SRC_W'(NUM_SRC - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PASS  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [SRC_W-1:0]    r_grant;
    logic [SRC_W-1:0]    r_rrPtr;
    logic [c_CNT_W-1:0]  r_beatCnt;
    logic                r_ovErr;

    logic [1:0]          w_stateNxt;
    logic [SRC_W-1:0]    w_grantNxt;
    logic [SRC_W-1:0]    w_rrPtrNxt;
    logic [c_CNT_W-1:0]  w_beatCntNxt;
    logic                w_ovErrNxt;

    logic [31:0]         w_srcData [NUM_SRC];
    logic [31:0]         w_gData;
    logic                w_gVal;
    logic                w_gLast;
    logic                w_cntAtLast;
    logic [SRC_W-1:0]    w_nextSrc;
    logic                w_found;
    logic [SRC_W-1:0]    w_pick;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_srcData[gi] = src_data[32*gi +: 32];
        end
    endgenerate

    assign w_gData     = w_srcData[r_grant];
    assign w_gVal      = src_val[r_grant];
    assign w_gLast     = src_last[r_grant];
    assign w_cntAtLast = (r_beatCnt == c_CNT_LAST);
    // Source after the granted one, wrapping for any NUM_SRC (not only 2^n).
    assign w_nextSrc   = (r_grant == c_LAST_SRC) ? '0 : r_grant + 1'b1;

    // Round-robin search: first enabled requester at or after r_rrPtr.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(r_rrPtr) + k) % NUM_SRC;
            if (!w_found && src_val[idx] && src_en[idx]) begin
                w_found = 1'b1;
                w_pick  = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        w_stateNxt   = r_state;
        w_grantNxt   = r_grant;
        w_rrPtrNxt   = r_rrPtr;
        w_beatCntNxt = r_beatCnt;
        w_ovErrNxt   = 1'b0;
        src_ready    = '0;
        out_data     = '0;
        out_val      = 1'b0;
        out_last     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_grantNxt   = w_pick;
                    w_beatCntNxt = '0;
                    w_stateNxt   = c_ST_PASS;
                end
            end

            c_ST_PASS: begin
                out_data           = w_gData;
                out_val            = w_gVal;
                out_last           = w_gLast | w_cntAtLast;
                src_ready[r_grant] = out_ready;
                if (w_gVal && out_ready) begin
                    if (r_beatCnt != c_CNT_SAT) begin
                        w_beatCntNxt = r_beatCnt + 1'b1;
                    end
                    if (w_gLast) begin
                        // A packet of exactly MAX_BEATS ends here cleanly.
                        w_stateNxt = c_ST_IDLE;
                        w_rrPtrNxt = w_nextSrc;
                    end else if (w_cntAtLast) begin
                        w_stateNxt = c_ST_DRAIN;
                        w_ovErrNxt = 1'b1;
                    end
                end
            end

            c_ST_DRAIN: begin
                // Swallow the rest of the oversize packet without the parser.
                src_ready[r_grant] = 1'b1;
                if (w_gVal && w_gLast) begin
                    w_stateNxt = c_ST_IDLE;
                    w_rrPtrNxt = w_nextSrc;
                end
            end

            default: begin
                w_stateNxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_grant   <= '0;
            r_rrPtr   <= '0;
            r_beatCnt <= '0;
            r_ovErr   <= 1'b0;
        end else begin
            r_state   <= w_stateNxt;
            r_grant   <= w_grantNxt;
            r_rrPtr   <= w_rrPtrNxt;
            r_beatCnt <= w_beatCntNxt;
            r_ovErr   <= w_ovErrNxt;
        end
    end

    assign busy         = (r_state == c_ST_PASS) || (r_state == c_ST_DRAIN);
    assign out_src      = busy ? r_grant : '0;
    assign oversize_err = r_ovErr;

endmodule
`default_nettype wire

// File: tb/tb_parser_in_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parser_in_arb
//  Purpose  : Self-checking bench for parser_in_arb. Sources are fed from
//             per-source beat queues; a cycle-level behavioural model and a
//             per-source expected-beat scoreboard are compared against the
//             DUT each cycle, plus literal expectations for directed cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parser_in_arb;

    localparam int NUM_SRC   = 4;
    localparam int MAX_BEATS = 12;
    localparam int SRC_W     = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_SRC*32-1:0] src_data;
    logic [NUM_SRC-1:0]    src_val;
    logic [NUM_SRC-1:0]    src_last;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC-1:0]    src_en;
    logic [31:0]           out_data;
    logic                  out_val;
    logic                  out_last;
    logic                  out_ready;
    logic [SRC_W-1:0]      out_src;
    logic                  busy;
    logic                  oversize_err;

    parser_in_arb #(.NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS), .SRC_W(SRC_W)) dut (
        .clk(clk), .reset(reset),
        .src_data(src_data), .src_val(src_val), .src_last(src_last),
        .src_ready(src_ready), .src_en(src_en),
        .out_data(out_data), .out_val(out_val), .out_last(out_last),
        .out_ready(out_ready), .out_src(out_src),
        .busy(busy), .oversize_err(oversize_err)
    );

    always #5 clk = ~clk;

    // Source stimulus: {last, data} beats; expected parser-side beats per source.
    logic [32:0] srcQ [NUM_SRC][$];
    logic [32:0] expQ [NUM_SRC][$];
    logic [NUM_SRC-1:0] gate;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pktNum = 0;

    int readyPct = 100;
    int gatePct  = 100;
    bit patternEn = 0;
    bit enRand    = 0;
    bit checkZero = 0;

    // Reference model state: mode 0 idle, 1 passing, 2 draining.
    int mode = 0, mG = 0, mCnt = 0, mRr = 0;
    bit mErr = 0;

    // Observations of the DUT used for literal checks.
    int  grantLog[$];
    int  beats, lastCount, firstLastAt, errCount, busyCycles;
    logic [31:0] firstData;
    bit  prevBusy = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clearObs();
        grantLog.delete();
        beats = 0; lastCount = 0; firstLastAt = 0; errCount = 0; busyCycles = 0;
        firstData = '0;
    endtask

    task automatic addPkt(input int s, input int len, input int streamId, input int seq);
        logic [31:0] w;
        for (int b = 0; b < len; b++) begin
            if (b == 0)      w = {16'(streamId), 16'(len * 4)};
            else if (b == 1) w = 32'(seq);
            else             w = {8'(s), 8'(pktNum), 16'(b)};
            srcQ[s].push_back({(b == len - 1), w});
            if (b < MAX_BEATS) expQ[s].push_back({(b == len - 1) || (b == MAX_BEATS - 1), w});
        end
        pktNum++;
    endtask

    task automatic drive();
        logic [32:0] h;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (srcQ[i].size() > 0) begin
                h = srcQ[i][0];
                src_val[i]          = gate[i];
                src_data[32*i +: 32] = h[31:0];
                src_last[i]         = h[32];
            end else begin
                src_val[i]          = 1'b0;
                src_data[32*i +: 32] = '0;
                src_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [NUM_SRC-1:0] er;
        logic [32:0] h;
        logic [32:0] e;
        bit expVal;
        er = '0;
        if (mode == 1) er[mG] = out_ready;
        if (mode == 2) er[mG] = 1'b1;
        expVal = (mode == 1) && src_val[mG];
        chk("busy", 32'(busy), 32'(mode != 0));
        chk("oversize_err", 32'(oversize_err), 32'(mErr));
        chk("src_ready", 32'(src_ready), 32'(er));
        chk("out_val", 32'(out_val), 32'(expVal));
        if (expVal) begin
            h = srcQ[mG][0];
            chk("out_data", out_data, h[31:0]);
            chk("out_last", 32'(out_last), 32'(h[32] || (mCnt == MAX_BEATS - 1)));
        end
        if (mode != 0) chk("out_src", 32'(out_src), 32'(mG));
        if (checkZero) begin
            chk("zero_data", out_data, 32'h0);
            chk("zero_last", 32'(out_last), 32'h0);
            chk("zero_val", 32'(out_val), 32'h0);
            chk("zero_ready", 32'(src_ready), 32'h0);
            chk("zero_busy", 32'(busy), 32'h0);
            chk("zero_src", 32'(out_src), 32'h0);
            chk("zero_err", 32'(oversize_err), 32'h0);
            checkZero = 0;
        end
        // Observations and scoreboard on the parser-side transfers.
        if (busy && !prevBusy) grantLog.push_back(int'(out_src));
        prevBusy = busy;
        if (busy) busyCycles++;
        if (oversize_err) errCount++;
        if (!reset && out_val && out_ready) begin
            if (beats == 0) firstData = out_data;
            beats++;
            if (out_last) begin
                lastCount++;
                if (firstLastAt == 0) firstLastAt = beats;
            end
            if (expQ[out_src].size() == 0) begin
                chk("sb_unexpected_beat", 32'(out_src), 32'hFFFF_FFFF);
            end else begin
                e = expQ[out_src].pop_front();
                chk("sb_data", out_data, e[31:0]);
                chk("sb_last", 32'(out_last), 32'(e[32]));
            end
        end
    endtask

    task automatic step();
        int popSrc;
        bit found;
        int idx;
        @(negedge clk);
        compare();
        popSrc = -1;
        if (reset) begin
            mode = 0; mG = 0; mCnt = 0; mRr = 0; mErr = 0;
        end else begin
            bit nErr;
            nErr = 0;
            case (mode)
                0: begin
                    found = 0;
                    for (int k = 0; k < NUM_SRC; k++) begin
                        idx = (mRr + k) % NUM_SRC;
                        if (!found && src_val[idx] && src_en[idx]) begin
                            found = 1; mG = idx; mCnt = 0; mode = 1;
                        end
                    end
                end
                1: if (src_val[mG] && out_ready) begin
                    popSrc = mG;
                    if (src_last[mG]) begin
                        mode = 0; mRr = (mG + 1) % NUM_SRC;
                    end else if (mCnt == MAX_BEATS - 1) begin
                        mode = 2; nErr = 1;
                    end
                    if (mCnt < MAX_BEATS) mCnt++;
                end
                default: if (src_val[mG]) begin
                    popSrc = mG;
                    if (src_last[mG]) begin
                        mode = 0; mRr = (mG + 1) % NUM_SRC;
                    end
                end
            endcase
            mErr = nErr;
        end
        @(posedge clk);
        #1;
        if (popSrc >= 0) void'(srcQ[popSrc].pop_front());
        cyc++;
        out_ready = patternEn ? ((cyc % 3) == 0) : ($urandom_range(99) < readyPct);
        for (int i = 0; i < NUM_SRC; i++) gate[i] = ($urandom_range(99) < gatePct);
        if (enRand && $urandom_range(99) < 5) begin
            idx = $urandom_range(NUM_SRC - 1);
            src_en[idx] = ~src_en[idx];
        end
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_SRC; i++) if (srcQ[i].size() > 0) return 1;
        return (mode != 0);
    endfunction

    task automatic runUntilIdle(input int maxCyc);
        int n;
        n = 0;
        while (pending() && n < maxCyc) begin
            step();
            n++;
        end
        if (pending()) chk("timeout", 32'(n), 32'(maxCyc + 1));
    endtask

    task automatic chkGrants(input string nm, input int exp[$]);
        chk({nm, "_count"}, 32'(grantLog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < grantLog.size()) chk({nm, "_grant"}, 32'(grantLog[i]), 32'(exp[i]));
    endtask

    initial begin
        int e[$];
        int n;
        reset = 1'b1; src_en = '1; gate = '1; out_ready = 1'b1;
        src_data = '0; src_val = '0; src_last = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        checkZero = 1;
        step();

        // Single 5-beat packet from source 1.
        clearObs();
        addPkt(1, 5, 12, 0); drive();
        runUntilIdle(50); step(); step();
        e = '{1}; chkGrants("single", e);
        chk("single_beats", 32'(beats), 32'd5);
        chk("single_last_at", 32'(firstLastAt), 32'd5);
        chk("single_busy_cycles", 32'(busyCycles), 32'd5);
        chk("single_first_word", firstData, 32'h000C_0014);

        // Round robin after reset, all sources requesting.
        reset = 1'b1; step(); reset = 1'b0;
        clearObs();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NUM_SRC; s++) addPkt(s, 3, s, p);
        drive();
        runUntilIdle(100); step();
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; chkGrants("rr", e);
        chk("rr_beats", 32'(beats), 32'd24);

        // Backpressure on source 2.
        clearObs(); patternEn = 1;
        addPkt(2, 6, 7, 9); drive();
        runUntilIdle(100); step();
        patternEn = 0; out_ready = 1'b1;
        e = '{2}; chkGrants("bp", e);
        chk("bp_beats", 32'(beats), 32'd6);
        chk("bp_last_at", 32'(firstLastAt), 32'd6);

        // Oversize on source 0, then source 1 gets the next grant.
        clearObs();
        addPkt(0, 14, 3, 1); addPkt(1, 2, 4, 2); drive();
        runUntilIdle(100); step(); step();
        e = '{0, 1}; chkGrants("ovs", e);
        chk("ovs_beats", 32'(beats), 32'd14);
        chk("ovs_last_at", 32'(firstLastAt), 32'd12);
        chk("ovs_last_count", 32'(lastCount), 32'd2);
        chk("ovs_err_pulses", 32'(errCount), 32'd1);

        // Exactly MAX_BEATS with last: no error.
        clearObs();
        addPkt(0, MAX_BEATS, 3, 5); drive();
        runUntilIdle(100); step(); step();
        chk("max_beats", 32'(beats), 32'd12);
        chk("max_err_pulses", 32'(errCount), 32'd0);

        // Enable mask 1010.
        clearObs();
        src_en = 4'b1010;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NUM_SRC; s++) addPkt(s, 2, s, p);
        drive();
        for (int i = 0; i < 30; i++) step();
        e = '{1, 3, 1, 3}; chkGrants("mask", e);
        // Disable source 1 while its packet is in flight.
        clearObs();
        addPkt(1, 5, 1, 8); drive();
        n = 0;
        while (!(busy && out_src == 2'd1) && n < 20) begin step(); n++; end
        chk("mask_grant_seen", 32'(busy && out_src == 2'd1), 32'd1);
        src_en = 4'b1000;
        for (int i = 0; i < 15; i++) step();
        chk("mask_midpkt_beats", 32'(beats), 32'd5);
        chk("mask_midpkt_last", 32'(lastCount), 32'd1);
        src_en = '1;
        runUntilIdle(200); step();

        // Reset on beat 3 of a 5-beat packet from source 2.
        clearObs();
        addPkt(2, 5, 2, 3); drive();
        n = 0;
        while (beats < 2 && n < 20) begin step(); n++; end
        chk("rst_reached_beat3", 32'(beats), 32'd2);
        reset = 1'b1; step(); reset = 1'b0;
        srcQ[2].delete(); expQ[2].delete();
        checkZero = 1;
        clearObs();
        addPkt(3, 2, 3, 0); addPkt(0, 2, 0, 0); drive();
        runUntilIdle(50); step();
        e = '{0, 3}; chkGrants("rst", e);

        // Randomised traffic.
        readyPct = 70; gatePct = 80; enRand = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 10)
                addPkt($urandom_range(NUM_SRC - 1), $urandom_range(15, 1), $urandom_range(255), i);
            step();
        end
        enRand = 0; src_en = '1;
        runUntilIdle(20000); step(); step();
        n = 0;
        for (int i = 0; i < NUM_SRC; i++) n += expQ[i].size();
        chk("sb_leftover", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
